// File: rtl/lb_pkg.sv
// Shared constants and pointer helpers for the line window buffer.
// Border replication is enabled by defining LB_BORDER_REPLICATE_EN.
package lb_pkg;

    localparam int LB_DATA_W   = 8;
    localparam int LB_LINE_LEN = 480;
    localparam int LB_TAPS     = 3;

    // Circular increment: len-1 returns to 0 for any len, power of two or not.
    function automatic int unsigned lb_wrap_inc(input int unsigned ptr, input int unsigned len);
        return (ptr >= len - 1) ? 0 : ptr + 1;
    endfunction

    // Column of tap k, either wrapping into the next line or clamped to its last pixel.
    function automatic int unsigned lb_tap_addr(input int unsigned ptr, input int unsigned k,
                                                input int unsigned len, input bit replicate);
        int unsigned col;
        col = ptr + k;
        if (col >= len)
            col = replicate ? len - 1 : col - len;
        return col;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Line storage: one synchronous write port and TAPS asynchronous read ports.
module line_ram #(
    parameter int DATA_W   = 8,
    parameter int LINE_LEN = 480,
    parameter int TAPS     = 3,
    parameter int ADDR_W   = 9
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [TAPS*ADDR_W-1:0]   raddr,
    output logic [TAPS*DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [LINE_LEN];

    // NOTE: the array has no reset; occupancy in the parent decides what is valid,
    // and leaving it unreset lets the tools map it onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < TAPS; k++)
            rdata[k*DATA_W +: DATA_W] = mem[raddr[k*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/line_window_buffer.sv
// Single-line circular pixel buffer presenting a TAPS-wide horizontal window.
// Define LB_BORDER_REPLICATE_EN to clamp taps to the last pixel of the line.
module line_window_buffer
    import lb_pkg::*;
#(
    parameter int DATA_W   = LB_DATA_W,
    parameter int LINE_LEN = LB_LINE_LEN,
    parameter int TAPS     = LB_TAPS
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_data_valid,
    input  logic                          i_rd_data,
    output logic [TAPS*DATA_W-1:0]        o_data,
    output logic                          o_rd_ready,
    output logic [$clog2(LINE_LEN+1)-1:0] o_level,
    output logic                          o_overflow,
    output logic                          o_underflow,
    output logic                          o_line_done
);

    localparam int PTR_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int LVL_W = $clog2(LINE_LEN + 1);

`ifdef LB_BORDER_REPLICATE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [LVL_W-1:0]        level;
    logic [LVL_W-1:0]        need;
    logic                    rd_ready;
    logic                    rd_acc;
    logic                    wr_acc;
    logic [TAPS*PTR_W-1:0]   tap_addr;
    logic [TAPS*DATA_W-1:0]  ram_rdata;

    // Near the end of a line only the pixels left in it are needed when replicating.
    always_comb begin
        need = LVL_W'(TAPS);
`ifdef LB_BORDER_REPLICATE_EN
        if (LINE_LEN - 32'(rd_ptr) < TAPS)
            need = LVL_W'(LINE_LEN - 32'(rd_ptr));
`endif
    end

    assign rd_ready = (level >= need);
    assign rd_acc   = i_rd_data && rd_ready;
    // A read in the same cycle frees the cell being written at full.
    assign wr_acc   = i_data_valid && ((level < LVL_W'(LINE_LEN)) || rd_acc);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        tap_addr = '0;
        for (int k = 0; k < TAPS; k++)
            tap_addr[k*PTR_W +: PTR_W] =
                PTR_W'(lb_tap_addr(32'(rd_ptr), k, LINE_LEN, REPLICATE));
    end

    line_ram #(
        .DATA_W   (DATA_W),
        .LINE_LEN (LINE_LEN),
        .TAPS     (TAPS),
        .ADDR_W   (PTR_W)
    ) u_ram (
        .clk   (i_clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (i_data),
        .raddr (tap_addr),
        .rdata (ram_rdata)
    );

    // Tap 0 goes to the most significant slice of the output window.
    always_comb begin
        o_data = '0;
        for (int k = 0; k < TAPS; k++)
            o_data[(TAPS-1-k)*DATA_W +: DATA_W] = ram_rdata[k*DATA_W +: DATA_W];
    end

    assign o_rd_ready = rd_ready;
    assign o_level    = level;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            o_line_done <= 1'b0;
        end else begin
            o_overflow  <= i_data_valid && !wr_acc;
            o_underflow <= i_rd_data && !rd_ready;
            o_line_done <= rd_acc && (rd_ptr == PTR_W'(LINE_LEN - 1));

            if (wr_acc)
                wr_ptr <= PTR_W'(lb_wrap_inc(32'(wr_ptr), LINE_LEN));
            if (rd_acc)
                rd_ptr <= PTR_W'(lb_wrap_inc(32'(rd_ptr), LINE_LEN));

            case ({wr_acc, rd_acc})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// Randomized bench for line_window_buffer against a queue-based stream model.
// Honours LB_BORDER_REPLICATE_EN the same way as the design.
module tb_line_window_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = '0;
    logic       valid = 1'b0;
    logic       rd = 1'b0;

    logic [23:0] a_data, b_data;
    logic        a_rdy, b_rdy, a_ovf, b_ovf, a_unf, b_unf, a_ld, b_ld;
    logic [8:0]  a_level;
    logic [2:0]  b_level;

    always #5 clk = ~clk;

    line_window_buffer #(.DATA_W(8), .LINE_LEN(480), .TAPS(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_valid(valid), .i_rd_data(rd),
        .o_data(a_data), .o_rd_ready(a_rdy), .o_level(a_level),
        .o_overflow(a_ovf), .o_underflow(a_unf), .o_line_done(a_ld)
    );

    line_window_buffer #(.DATA_W(8), .LINE_LEN(5), .TAPS(3)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_valid(valid), .i_rd_data(rd),
        .o_data(b_data), .o_rd_ready(b_rdy), .o_level(b_level),
        .o_overflow(b_ovf), .o_underflow(b_unf), .o_line_done(b_ld)
    );

    // sel picks which instance is observed and which line length the model uses.
    bit          sel = 1'b0;
    logic [23:0] obs_data;
    logic [8:0]  obs_level;
    logic        obs_rdy, obs_ovf, obs_unf, obs_ld;

    assign obs_data  = sel ? b_data : a_data;
    assign obs_level = sel ? {6'b0, b_level} : a_level;
    assign obs_rdy   = sel ? b_rdy : a_rdy;
    assign obs_ovf   = sel ? b_ovf : a_ovf;
    assign obs_unf   = sel ? b_unf : a_unf;
    assign obs_ld    = sel ? b_ld : a_ld;

    int n_cmp = 0;
    int n_err = 0;

    // Model: the unconsumed pixel stream in order, plus the column of its head.
    logic [7:0] mq[$];
    int         rd_col = 0;
    logic       exp_ovf = 1'b0, exp_unf = 1'b0, exp_ld = 1'b0;

    function automatic int m_len();
        return sel ? 5 : 480;
    endfunction

    function automatic int m_need();
`ifdef LB_BORDER_REPLICATE_EN
        int rem;
        rem = m_len() - rd_col;
        return (rem < 3) ? rem : 3;
`else
        return 3;
`endif
    endfunction

    function automatic logic m_ready();
        return mq.size() >= m_need();
    endfunction

    function automatic logic [23:0] m_window();
        logic [23:0] w;
        int idx;
        w = 'x;
        for (int k = 0; k < 3; k++) begin
            idx = k;
`ifdef LB_BORDER_REPLICATE_EN
            if (rd_col + k > m_len() - 1) idx = m_len() - 1 - rd_col;
`endif
            if (idx < mq.size()) w[(2-k)*8 +: 8] = mq[idx];
        end
        return w;
    endfunction

    // Drive one cycle of stimulus from a negedge and advance the model to match.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        logic racc, wacc;
        valid = v; data = d; rd = r;
        racc = r && m_ready();
        wacc = v && ((mq.size() < m_len()) || racc);
        exp_ovf = v && !wacc;
        exp_unf = r && !m_ready();
        exp_ld  = racc && (rd_col == m_len() - 1);
        if (racc) begin
            void'(mq.pop_front());
            rd_col = (rd_col + 1) % m_len();
        end
        if (wacc) mq.push_back(d);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0; rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0; rd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        rd_col = 0;
        exp_ovf = 1'b0; exp_unf = 1'b0; exp_ld = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        n_cmp++; if (obs_level !== 9'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", obs_level); end
        n_cmp++; if (obs_rdy !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", obs_rdy); end
        n_cmp++; if ({obs_ovf, obs_unf, obs_ld} !== 3'b000)
            begin n_err++; $display("FAIL reset_flags got %b want 000", {obs_ovf, obs_unf, obs_ld}); end
    endtask

    task automatic test_first_window();
        sel = 1'b0;
        do_reset();
        step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        n_cmp++; if (obs_rdy !== 1'b0) begin n_err++; $display("FAIL first_ready_early got %b want 0", obs_rdy); end
        step(1'b1, 8'h12, 1'b0);
        n_cmp++; if (obs_rdy !== 1'b1) begin n_err++; $display("FAIL first_ready got %b want 1", obs_rdy); end
        n_cmp++; if (obs_data !== 24'h101112) begin n_err++; $display("FAIL first_data got %h want 101112", obs_data); end
        n_cmp++; if (obs_level !== 9'd3) begin n_err++; $display("FAIL first_level got %0d want 3", obs_level); end
    endtask

    task automatic test_overflow();
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 480; i++) step(1'b1, 8'($urandom), 1'b0);
        n_cmp++; if (obs_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_at_fill got %b want 0", obs_ovf); end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom), 1'b0);
            n_cmp++; if (obs_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pulse[%0d] got %b want 1", i, obs_ovf); end
            n_cmp++; if (obs_level !== 9'd480) begin n_err++; $display("FAIL ovf_level[%0d] got %0d want 480", i, obs_level); end
        end
        step(1'b0, 8'h00, 1'b0);
        n_cmp++; if (obs_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", obs_ovf); end
        // Drain and confirm the dropped writes never touched the stored line.
        for (int i = 0; i < 478; i++) begin
            n_cmp++; if (obs_data !== m_window())
                begin n_err++; $display("FAIL ovf_contents[%0d] got %h want %h", i, obs_data, m_window()); end
            step(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_full_stream();
        int ld_count;
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 480; i++) step(1'b1, 8'($urandom), 1'b0);
        ld_count = 0;
        for (int i = 0; i < 480; i++) begin
            n_cmp++; if (obs_data !== m_window())
                begin n_err++; $display("FAIL stream_data[%0d] got %h want %h", i, obs_data, m_window()); end
            step(1'b1, 8'($urandom), 1'b1);
            n_cmp++; if (obs_level !== 9'd480) begin n_err++; $display("FAIL stream_level[%0d] got %0d want 480", i, obs_level); end
            n_cmp++; if (obs_ld !== exp_ld) begin n_err++; $display("FAIL stream_ld[%0d] got %b want %b", i, obs_ld, exp_ld); end
            if (obs_ld === 1'b1) ld_count++;
        end
        n_cmp++; if (ld_count != 1) begin n_err++; $display("FAIL stream_ld_count got %0d want 1", ld_count); end
    endtask

    task automatic test_underflow();
        logic [7:0] p0;
        sel = 1'b0;
        do_reset();
        p0 = 8'($urandom);
        step(1'b1, p0, 1'b0);
        step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        n_cmp++; if (obs_unf !== 1'b1) begin n_err++; $display("FAIL unf_pulse got %b want 1", obs_unf); end
        n_cmp++; if (obs_level !== 9'd2) begin n_err++; $display("FAIL unf_level got %0d want 2", obs_level); end
        step(1'b1, 8'($urandom), 1'b0);
        n_cmp++; if (obs_unf !== 1'b0) begin n_err++; $display("FAIL unf_clear got %b want 0", obs_unf); end
        n_cmp++; if (obs_data[23:16] !== p0) begin n_err++; $display("FAIL unf_rdptr tap0 got %h want %h", obs_data[23:16], p0); end
        n_cmp++; if (obs_data !== m_window()) begin n_err++; $display("FAIL unf_window got %h want %h", obs_data, m_window()); end
    endtask

    task automatic test_mid_reset();
        logic [23:0] w;
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 200; i++) step(1'b1, 8'($urandom), 1'b0);
        n_cmp++; if (obs_level !== 9'd200) begin n_err++; $display("FAIL midrst_pre_level got %0d want 200", obs_level); end
        do_reset();
        n_cmp++; if (obs_level !== 9'd0) begin n_err++; $display("FAIL midrst_level got %0d want 0", obs_level); end
        n_cmp++; if (obs_rdy !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b want 0", obs_rdy); end
        w = {8'($urandom), 8'($urandom), 8'($urandom)};
        step(1'b1, w[23:16], 1'b0);
        step(1'b1, w[15:8], 1'b0);
        step(1'b1, w[7:0], 1'b0);
        n_cmp++; if (obs_data !== w) begin n_err++; $display("FAIL midrst_addr0 got %h want %h", obs_data, w); end
    endtask

    task automatic test_short_line();
        sel = 1'b1;
        do_reset();
        for (int p = 1; p <= 5; p++) step(1'b1, 8'(p), 1'b0);
        step(1'b1, 8'd6, 1'b1);
        step(1'b1, 8'd7, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        n_cmp++; if (obs_level !== 9'd3) begin n_err++; $display("FAIL short_level got %0d want 3", obs_level); end
`ifdef LB_BORDER_REPLICATE_EN
        n_cmp++; if (obs_data !== 24'h050505) begin n_err++; $display("FAIL short_data got %h want 050505", obs_data); end
`else
        n_cmp++; if (obs_data !== 24'h050607) begin n_err++; $display("FAIL short_data got %h want 050607", obs_data); end
`endif
        n_cmp++; if (obs_data !== m_window()) begin n_err++; $display("FAIL short_model got %h want %h", obs_data, m_window()); end
        step(1'b0, 8'd0, 1'b1);
        n_cmp++; if (obs_ld !== 1'b1) begin n_err++; $display("FAIL short_line_done got %b want 1", obs_ld); end

        do_reset();
        for (int p = 1; p <= 5; p++) step(1'b1, 8'(p), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1);
`ifdef LB_BORDER_REPLICATE_EN
        n_cmp++; if (obs_level !== 9'd1) begin n_err++; $display("FAIL short_tail_level got %0d want 1", obs_level); end
        n_cmp++; if (obs_rdy !== 1'b1) begin n_err++; $display("FAIL short_tail_ready got %b want 1", obs_rdy); end
        n_cmp++; if (obs_data !== 24'h050505) begin n_err++; $display("FAIL short_tail_data got %h want 050505", obs_data); end
`else
        n_cmp++; if (obs_level !== 9'd2) begin n_err++; $display("FAIL short_tail_level got %0d want 2", obs_level); end
        n_cmp++; if (obs_unf !== 1'b1) begin n_err++; $display("FAIL short_tail_unf got %b want 1", obs_unf); end
        n_cmp++; if (obs_rdy !== 1'b0) begin n_err++; $display("FAIL short_tail_ready got %b want 0", obs_rdy); end
`endif
    endtask

    task automatic test_random(input bit which, input int cycles);
        int pv, pr;
        sel = which;
        do_reset();
        for (int i = 0; i < cycles; i++) begin
            if (i % 200 == 0) begin pv = $urandom_range(20, 90); pr = $urandom_range(20, 90); end
            step($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pr);
            n_cmp++; if (obs_level !== 9'(mq.size()))
                begin n_err++; $display("FAIL rnd%0d_level[%0d] got %0d want %0d", which, i, obs_level, mq.size()); end
            n_cmp++; if (obs_rdy !== m_ready())
                begin n_err++; $display("FAIL rnd%0d_ready[%0d] got %b want %b", which, i, obs_rdy, m_ready()); end
            n_cmp++; if ({obs_ovf, obs_unf, obs_ld} !== {exp_ovf, exp_unf, exp_ld})
                begin n_err++; $display("FAIL rnd%0d_flags[%0d] got %b want %b", which, i,
                                        {obs_ovf, obs_unf, obs_ld}, {exp_ovf, exp_unf, exp_ld}); end
            if (m_ready()) begin
                n_cmp++; if (obs_data !== m_window())
                    begin n_err++; $display("FAIL rnd%0d_data[%0d] got %h want %h", which, i, obs_data, m_window()); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_window();
        test_overflow();
        test_full_stream();
        test_underflow();
        test_mid_reset();
        test_short_line();
        test_random(1'b0, 3000);
        test_random(1'b1, 1500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
